// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared types and defaults for the regArray write-port arbiter
//
// Purpose : package regarb_pkg, imported by the interface, the arbiter and the top.
// Contents: default widths, DEPTH, FSM state enum, grant encoding and a grant helper.
// Ports   : none (package).
package regarb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  // The requester that did not win last time; used for round-robin ties.
  function automatic grant_e other_grant(input grant_e g);
    return (g == GNT_A) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester handshakes, clear control and regArray write port
//
// Purpose : bundles both requester valid/ready channels, the clear-sweep control
//           and the registered write port towards regArray.
// Ports   : aValid/aAddr/aData, bValid/bAddr/bData, initReq   (master -> slave)
//           aReady, bReady, initBusy, writeEnable/writeAddr/dataIn (slave -> master)
// Modports: master = requesters / environment, slave = reg_write_arbiter.
interface reg_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              aValid;
  logic              aReady;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aData;

  logic              bValid;
  logic              bReady;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bData;

  logic              initReq;
  logic              initBusy;

  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] dataIn;

  modport master (
    output aValid, aAddr, aData,
    output bValid, bAddr, bData,
    output initReq,
    input  aReady, bReady, initBusy,
    input  writeEnable, writeAddr, dataIn
  );

  modport slave (
    input  aValid, aAddr, aData,
    input  bValid, bAddr, bData,
    input  initReq,
    output aReady, bReady, initBusy,
    output writeEnable, writeAddr, dataIn
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arb2.sv
// rtl/reg_write_arbiter_rr_arb2.sv - combinational two-input write grant
//
// Purpose : picks which requester owns the write port this cycle.
// Macro   : REGARB_FIXED_PRIO_EN selects fixed priority (A always wins ties);
//           undefined gives round-robin using i_last_grant.
// Ports   : i_a_valid, i_b_valid  requester valids
//           i_last_grant          winner of the most recent transfer
//           o_grant               current grant (always one of GNT_A/GNT_B)
module rr_arb2
  import regarb_pkg::*;
(
  input  logic   i_a_valid,
  input  logic   i_b_valid,
  input  grant_e i_last_grant,
  output grant_e o_grant
);

`ifdef REGARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last_grant;

  always_comb begin
    o_grant = GNT_A;
    if (i_b_valid && !i_a_valid) o_grant = GNT_B;
  end
`else
  // With no valid or both valid the grant parks on the requester that did not
  // win last, so a tie always alternates and the idle grant is already fair.
  always_comb begin
    o_grant = other_grant(i_last_grant);
    if (i_a_valid && !i_b_valid)      o_grant = GNT_A;
    else if (i_b_valid && !i_a_valid) o_grant = GNT_B;
  end
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - write-port controller with clear sweep for the 16 x 4 regArray
//
// Purpose : shares the regArray write port between requesters A and B and
//           zero-fills every entry after reset and on initReq.
// Macro   : REGARB_FIXED_PRIO_EN (see rr_arb2) selects fixed A-priority.
// Ports   : clk          system clock, rising edge
//           clr          synchronous active-low reset
//           bus (slave)  requester handshakes, initReq/initBusy, registered
//                        writeEnable/writeAddr/dataIn towards regArray
module reg_write_arbiter
  import regarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               clr,
  reg_write_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            r_state;
  logic [ADDR_W-1:0] r_sweep_cnt;
  grant_e            r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  grant_e w_grant;
  logic   w_run;
  logic   w_a_xfer;
  logic   w_b_xfer;

  rr_arb2 u_arb (
    .i_a_valid    (bus.aValid),
    .i_b_valid    (bus.bValid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_run    = (r_state == RUN);
  assign w_a_xfer = w_run && (w_grant == GNT_A) && bus.aValid;
  assign w_b_xfer = w_run && (w_grant == GNT_B) && bus.bValid;

  assign bus.aReady      = w_run && (w_grant == GNT_A);
  assign bus.bReady      = w_run && (w_grant == GNT_B);
  assign bus.initBusy    = (r_state == SWEEP);
  assign bus.writeEnable = r_we;
  assign bus.writeAddr   = r_waddr;
  assign bus.dataIn      = r_wdata;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state      <= SWEEP;
      r_sweep_cnt  <= '0;
      r_last_grant <= GNT_B;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        SWEEP: begin
          r_we        <= 1'b1;
          r_waddr     <= r_sweep_cnt;
          r_wdata     <= '0;
          r_sweep_cnt <= r_sweep_cnt + ADDR_W'(1);
          if (r_sweep_cnt == LAST_ADDR) r_state <= RUN;
        end
        RUN: begin
          if (w_a_xfer) begin
            r_we         <= 1'b1;
            r_waddr      <= bus.aAddr;
            r_wdata      <= bus.aData;
            r_last_grant <= GNT_A;
          end else if (w_b_xfer) begin
            r_we         <= 1'b1;
            r_waddr      <= bus.bAddr;
            r_wdata      <= bus.bData;
            r_last_grant <= GNT_B;
          end else begin
            r_we <= 1'b0;
          end
          // A transfer accepted alongside initReq is still registered above;
          // it reaches regArray in the first sweep cycle.
          if (bus.initReq) begin
            r_state     <= SWEEP;
            r_sweep_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic clk;
  logic clr;
  int   pass_cnt;
  int   total_cnt;

  reg_write_arbiter_if bus ();

  reg_write_arbiter dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // regArray stand-in: captures on the rising edge while writeEnable is high.
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (bus.writeEnable) mem[bus.writeAddr] <= bus.dataIn;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0.
  task automatic do_reset;
    clr = 1'b0;
    step();
    clr = 1'b1;
  endtask

  task automatic test_reset;
    bus.aValid = 1'b0; bus.aAddr = '0; bus.aData = '0;
    bus.bValid = 1'b0; bus.bAddr = '0; bus.bData = '0;
    bus.initReq = 1'b0;
    do_reset();
    total_cnt++;
    if (bus.writeEnable !== 1'b0) $display("FAIL reset_we got %b want 0", bus.writeEnable);
    else pass_cnt++;
    total_cnt++;
    if (bus.writeAddr !== 4'd0) $display("FAIL reset_addr got %0h want 0", bus.writeAddr);
    else pass_cnt++;
    total_cnt++;
    if (bus.dataIn !== 4'd0) $display("FAIL reset_data got %0h want 0", bus.dataIn);
    else pass_cnt++;
    total_cnt++;
    if (bus.initBusy !== 1'b1) $display("FAIL reset_busy got %b want 1", bus.initBusy);
    else pass_cnt++;
    total_cnt++;
    if ({bus.aReady, bus.bReady} !== 2'b00)
      $display("FAIL reset_ready got %b want 00", {bus.aReady, bus.bReady});
    else pass_cnt++;
  endtask

  task automatic test_reset_sweep;
    for (int c = 1; c <= 16; c++) begin
      step();
      total_cnt++;
      if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'(c - 1), 4'd0})
        $display("FAIL sweep_write c=%0d got we=%b addr=%0h data=%0h want we=1 addr=%0h data=0",
                 c, bus.writeEnable, bus.writeAddr, bus.dataIn, c - 1);
      else pass_cnt++;
      total_cnt++;
      if (c < 16) begin
        if ({bus.initBusy, bus.aReady, bus.bReady} !== 3'b100)
          $display("FAIL sweep_ready c=%0d got busy,a,b=%b want 100", c,
                   {bus.initBusy, bus.aReady, bus.bReady});
        else pass_cnt++;
      end else begin
        if ({bus.initBusy, bus.aReady, bus.bReady} !== 3'b010)
          $display("FAIL run_ready c=%0d got busy,a,b=%b want 010", c,
                   {bus.initBusy, bus.aReady, bus.bReady});
        else pass_cnt++;
      end
    end
    step();
    total_cnt++;
    if (bus.writeEnable !== 1'b0) $display("FAIL post_sweep_we got %b want 0", bus.writeEnable);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (mem[i] !== 4'd0) $display("FAIL sweep_mem[%0d] got %0h want 0", i, mem[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_write;
    bus.aValid = 1'b1; bus.aAddr = 4'd3; bus.aData = 4'd9;
    #1;
    total_cnt++;
    if ({bus.aReady, bus.bReady} !== 2'b10)
      $display("FAIL single_ready got %b want 10", {bus.aReady, bus.bReady});
    else pass_cnt++;
    step();
    bus.aValid = 1'b0;
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'd3, 4'd9})
      $display("FAIL single_write got we=%b addr=%0h data=%0h want 1/3/9",
               bus.writeEnable, bus.writeAddr, bus.dataIn);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem[3] !== 4'd9) $display("FAIL single_read got %0h want 9", mem[3]);
    else pass_cnt++;
    total_cnt++;
    if (bus.writeEnable !== 1'b0) $display("FAIL single_idle_we got %b want 0", bus.writeEnable);
    else pass_cnt++;
  endtask

  task automatic test_early_valid;
    do_reset();
    bus.bValid = 1'b1; bus.bAddr = 4'd2; bus.bData = 4'd4;
    #1;
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (bus.bReady !== 1'b0) $display("FAIL early_bready c=%0d got %b want 0", c, bus.bReady);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (bus.bReady !== 1'b1) $display("FAIL early_accept got %b want 1", bus.bReady);
    else pass_cnt++;
    step();
    bus.bValid = 1'b0;
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'd2, 4'd4})
      $display("FAIL early_write got we=%b addr=%0h data=%0h want 1/2/4",
               bus.writeEnable, bus.writeAddr, bus.dataIn);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem[2] !== 4'd4) $display("FAIL early_read got %0h want 4", mem[2]);
    else pass_cnt++;
  endtask

  task automatic test_contention;
    bus.aValid = 1'b1; bus.aAddr = 4'd5; bus.aData = 4'hA;
    bus.bValid = 1'b1; bus.bAddr = 4'd5; bus.bData = 4'hB;
    #1;
`ifdef REGARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({bus.aReady, bus.bReady} !== 2'b10)
        $display("FAIL fixed_starve k=%0d got %b want 10", k, {bus.aReady, bus.bReady});
      else pass_cnt++;
      step();
    end
    bus.aValid = 1'b0;
    #1;
`else
    total_cnt++;
    if ({bus.aReady, bus.bReady} !== 2'b10)
      $display("FAIL rr_first got %b want 10", {bus.aReady, bus.bReady});
    else pass_cnt++;
    step();
    bus.aValid = 1'b0;
    #1;
`endif
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'd5, 4'hA})
      $display("FAIL cont_write_a got we=%b addr=%0h data=%0h want 1/5/a",
               bus.writeEnable, bus.writeAddr, bus.dataIn);
    else pass_cnt++;
    total_cnt++;
    if ({bus.aReady, bus.bReady} !== 2'b01)
      $display("FAIL cont_second got %b want 01", {bus.aReady, bus.bReady});
    else pass_cnt++;
    step();
    bus.bValid = 1'b0;
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'd5, 4'hB})
      $display("FAIL cont_write_b got we=%b addr=%0h data=%0h want 1/5/b",
               bus.writeEnable, bus.writeAddr, bus.dataIn);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem[5] !== 4'hB) $display("FAIL cont_last_wins got %0h want b", mem[5]);
    else pass_cnt++;
  endtask

  task automatic test_clear_request;
    bus.aValid = 1'b1; bus.aAddr = 4'd7; bus.aData = 4'd6;
    bus.initReq = 1'b1;
    #1;
    total_cnt++;
    if (bus.aReady !== 1'b1) $display("FAIL clr_accept got %b want 1", bus.aReady);
    else pass_cnt++;
    step();
    bus.aValid = 1'b0;
    bus.initReq = 1'b0;
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.dataIn, bus.initBusy} !== {1'b1, 4'd7, 4'd6, 1'b1})
      $display("FAIL clr_pending_write got we=%b addr=%0h data=%0h busy=%b want 1/7/6/1",
               bus.writeEnable, bus.writeAddr, bus.dataIn, bus.initBusy);
    else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      total_cnt++;
      if ({bus.aReady, bus.bReady} !== 2'b00)
        $display("FAIL clr_ready k=%0d got %b want 00", k, {bus.aReady, bus.bReady});
      else pass_cnt++;
      if (k >= 2) begin
        total_cnt++;
        if ({bus.writeEnable, bus.writeAddr, bus.dataIn} !== {1'b1, 4'(k - 2), 4'd0})
          $display("FAIL clr_sweep k=%0d got we=%b addr=%0h data=%0h want 1/%0h/0",
                   k, bus.writeEnable, bus.writeAddr, bus.dataIn, k - 2);
        else pass_cnt++;
      end
      step();
    end
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.initBusy} !== {1'b1, 4'd15, 1'b0})
      $display("FAIL clr_end got we=%b addr=%0h busy=%b want 1/f/0",
               bus.writeEnable, bus.writeAddr, bus.initBusy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem[7] !== 4'd0) $display("FAIL clr_entry7 got %0h want 0", mem[7]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep;
    do_reset();
    for (int c = 0; c < 7; c++) step();
    total_cnt++;
    if (bus.writeAddr !== 4'd6) $display("FAIL mid_pre_addr got %0h want 6", bus.writeAddr);
    else pass_cnt++;
    clr = 1'b0;
    step();
    total_cnt++;
    if ({bus.writeEnable, bus.writeAddr, bus.initBusy} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL mid_reset got we=%b addr=%0h busy=%b want 0/0/1",
               bus.writeEnable, bus.writeAddr, bus.initBusy);
    else pass_cnt++;
    clr = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      total_cnt++;
      if ({bus.writeEnable, bus.writeAddr} !== {1'b1, 4'(c - 1)})
        $display("FAIL mid_restart c=%0d got we=%b addr=%0h want 1/%0h",
                 c, bus.writeEnable, bus.writeAddr, c - 1);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (bus.writeEnable !== 1'b0) $display("FAIL mid_done_we got %b want 0", bus.writeEnable);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    clr = 1'b0;
    test_reset();
    test_reset_sweep();
    test_single_write();
    test_early_valid();
    test_contention();
    test_clear_request();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
